ucsbece154b_push_arbiter: RTL and testbench
===========================================

UCSBECE154B_PUSH_ARBITER -- requirements
Module: ucsbece154b_push_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, 32, payload width per requester SHALL be provided.
REQ-002 Parameter NR_REQ, 4, number of requesters SHALL be provided; legal range 2..8.
REQ-003 Parameter NR_ENTRIES, 4, depth of the internal queue SHALL be provided.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_i  input  NR_REQ  per-requester valid.
REQ-007 last_i  input  NR_REQ  per-requester end-of-packet flag, sampled with req_i.
REQ-008 data_i  input  NR_REQ*DATA_WIDTH  per-requester payload; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 ready_o  output  NR_REQ  per-requester grant/ready; at most one bit high.
REQ-010 data_o  output  DATA_WIDTH  payload at queue head.
REQ-011 id_o  output  ID_W  requester index of head entry; ID_W = max(1, clog2(NR_REQ)).
REQ-012 valid_o  output  1  queue non-empty.
REQ-013 pop_i  input  1  consumer dequeue; ignored when valid_o=0.
REQ-014 locked_o  output  1  high while in LOCKED state.

Function
REQ-015 A beat SHALL transfer from requester k in a cycle exactly when req_i[k] && ready_o[k]; the transferred beat SHALL be enqueued as {k, data_i[k]} and be visible at the head no earlier than the next cycle.
REQ-016 ready_o SHALL be combinational from req_i, current state, rr_ptr and queue-full; ready_o SHALL be all-zero whenever the queue is full, including a cycle with pop_i=1 while full.
REQ-017 The FSM SHALL have two states: ARB and LOCKED(owner).
REQ-018 In ARB, the grant SHALL go to the first requester with req_i set, searching rr_ptr, rr_ptr+1, ... wrapping modulo NR_REQ.
REQ-019 On any transfer from requester k, rr_ptr SHALL become (k+1) mod NR_REQ, wrapping NR_REQ-1 to 0.
REQ-020 A transfer in ARB with last_i[k]=0 SHALL enter LOCKED with owner=k; a transfer with last_i[k]=1 SHALL stay in ARB.
REQ-021 In LOCKED, only the owner SHALL be eligible for ready; other requesters SHALL be stalled even if the owner deasserts req_i.
REQ-022 A transfer from the owner with last_i=1 SHALL return the FSM to ARB on the next cycle; a transfer with last_i=0 SHALL remain LOCKED.
REQ-023 A single requester with continuous req_i and last_i=1 SHALL receive back-to-back grants every cycle while the queue is not full.
REQ-024 The queue SHALL be strict FIFO; pop with valid_o=1 SHALL advance the head one entry per cycle; push and pop in the same non-full cycle SHALL both take effect.
REQ-025 data_o and id_o SHALL be zero when valid_o=0.

Reset
REQ-026 While rst=1, the block SHALL assert ready_o=0 and valid_o=0.
REQ-027 On the cycle after rst is sampled high, the block SHALL be in ARB with rr_ptr=0 and the queue empty, with locked_o=0, data_o=0 and id_o=0.
REQ-028 Reset asserted mid-packet SHALL discard the lock and all queued entries with no partial-packet recovery.

Structure
REQ-029 Package ucsbece154b_arb_pkg SHALL hold the FSM state enum (ARB, LOCKED) and the ID_W width function.
REQ-030 The queue SHALL be one instance of ucsbece154b_fifo with DATA_WIDTH=DATA_WIDTH+ID_W and depth NR_ENTRIES, with push_i equal to the OR of req_i & ready_o.
REQ-031 The round-robin selection SHALL be a single combinational always block inside this module; there SHALL be no other sub-modules.

Verification
REQ-032 After reset, req_i=4'b1111 with last_i=all 1s and pop_i=1 continuously -> grants go to 0,1,2,3,0 on consecutive cycles, and id_o follows the same sequence one cycle later.
REQ-033 req_i=4'b0100 with last_i=0 for 2 beats (A1, A2) then 1 beat with last_i=1 (A3), while req_i[0]=1 throughout -> requester 0 gets no grant until the cycle after A3; locked_o=1 during the packet.
REQ-034 pop_i=0 with a single requester pushing 5 beats, NR_ENTRIES=4 -> 4 transfers, then ready_o=0 and full; with pop_i=1 while full, there is still no grant that cycle, and a grant occurs the following cycle.
REQ-035 rr_ptr=3 with only req_i[1] set -> grant to 1 (wrap search), and rr_ptr becomes 2.
REQ-036 Requester 2 in LOCKED drops req_i for 3 cycles while req_i[0]=1 -> no grants for those 3 cycles; requester 2 then resumes with last_i=1 and returns the FSM to ARB.
REQ-037 rst asserted in LOCKED with 3 entries queued -> the next cycle has valid_o=0 and locked_o=0, and the first grant afterwards goes to the lowest-index requester.

Source files
------------

// File: rtl/ucsbece154b_arb_pkg.sv
// Shared types for the push arbiter: FSM state encoding and the requester-id width helper.
package ucsbece154b_arb_pkg;

   typedef enum logic [0:0] {
      ARB    = 1'b0,
      LOCKED = 1'b1
   } arb_state_e;

   // A single requester still needs one id bit, so the width never drops below 1.
   function automatic int id_width(input int nr_req);
      return (nr_req > 2) ? $clog2(nr_req) : 1;
   endfunction

endpackage

// File: rtl/ucsbece154b_fifo.sv
// Strict FIFO with registered storage; pushes are dropped when full, pops are ignored when empty.
// data_o reads as zero while the queue is empty.
module ucsbece154b_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  pop_i,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  valid_o,
   output logic                  full_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  do_push, do_pop;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full_o  = (count_q == CW'(DEPTH));
   assign valid_o = (count_q != '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && valid_o;
   assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = data_i;
         wr_ptr_d        = next_ptr(wr_ptr_q);
      end
      if (do_pop) begin
         rd_ptr_d = next_ptr(rd_ptr_q);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only observable behind a valid count.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/ucsbece154b_push_arbiter.sv
// Round-robin push arbiter with packet locking, feeding a FIFO of {requester id, payload}.
// Handshake: a beat moves from requester k exactly in a cycle where req_i[k] && ready_o[k].
module ucsbece154b_push_arbiter
   import ucsbece154b_arb_pkg::*;
#(
   parameter int  DATA_WIDTH = 32,
   parameter int  NR_REQ     = 4,
   parameter int  NR_ENTRIES = 4,
   localparam int ID_W       = id_width(NR_REQ)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NR_REQ-1:0]            req_i,
   input  logic [NR_REQ-1:0]            last_i,
   input  logic [NR_REQ*DATA_WIDTH-1:0] data_i,
   output logic [NR_REQ-1:0]            ready_o,
   output logic [DATA_WIDTH-1:0]        data_o,
   output logic [ID_W-1:0]              id_o,
   output logic                         valid_o,
   input  logic                         pop_i,
   output logic                         locked_o
);

   arb_state_e                   state_q, state_d;
   logic [ID_W-1:0]              owner_q, owner_d;
   logic [ID_W-1:0]              rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]              grant_idx;
   logic                         grant_any;
   logic                         push;
   logic                         fifo_valid, fifo_full;
   logic [ID_W+DATA_WIDTH-1:0]   fifo_din, fifo_dout;

   // A full queue blocks every grant, even when the consumer pops in the same cycle.
   always_comb begin : rr_select
      ready_o   = '0;
      grant_idx = '0;
      grant_any = 1'b0;
      if (!rst && !fifo_full) begin
         if (state_q == LOCKED) begin
            if (req_i[owner_q]) begin
               grant_idx = owner_q;
               grant_any = 1'b1;
            end
         end else begin
            for (int i = 0; i < NR_REQ; i++) begin
               if (!grant_any && req_i[(int'(rr_ptr_q) + i) % NR_REQ]) begin
                  grant_idx = ID_W'((int'(rr_ptr_q) + i) % NR_REQ);
                  grant_any = 1'b1;
               end
            end
         end
         if (grant_any) begin
            ready_o[grant_idx] = 1'b1;
         end
      end
   end

   assign push     = |(req_i & ready_o);
   assign fifo_din = {grant_idx, data_i[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH]};

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      if (push) begin
         rr_ptr_d = (grant_idx == ID_W'(NR_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
         if (state_q == ARB && !last_i[grant_idx]) begin
            state_d = LOCKED;
            owner_d = grant_idx;
         end else if (state_q == LOCKED && last_i[grant_idx]) begin
            state_d = ARB;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ARB;
         owner_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   ucsbece154b_fifo #(
      .DATA_WIDTH (DATA_WIDTH + ID_W),
      .DEPTH      (NR_ENTRIES)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .data_i  (fifo_din),
      .pop_i   (pop_i),
      .data_o  (fifo_dout),
      .valid_o (fifo_valid),
      .full_o  (fifo_full)
   );

   assign valid_o  = fifo_valid && !rst;
   assign data_o   = valid_o ? fifo_dout[DATA_WIDTH-1:0] : '0;
   assign id_o     = valid_o ? fifo_dout[DATA_WIDTH +: ID_W] : '0;
   assign locked_o = (state_q == LOCKED) && !rst;

endmodule

// File: tb/tb_ucsbece154b_push_arbiter.sv
// Bench for the push arbiter: constant vector table, directed corner sequences and
// randomized traffic compared against a queue-based reference model.
module tb_ucsbece154b_push_arbiter;

   localparam int DW = 32;
   localparam int NR = 4;
   localparam int NE = 4;
   localparam int IW = 2;

   logic             clk;
   logic             rst;
   logic [NR-1:0]    req_i;
   logic [NR-1:0]    last_i;
   logic [NR*DW-1:0] data_i;
   logic [NR-1:0]    ready_o;
   logic [DW-1:0]    data_o;
   logic [IW-1:0]    id_o;
   logic             valid_o;
   logic             pop_i;
   logic             locked_o;

   int checks = 0;
   int errors = 0;

   // reference model state
   int               m_rr;
   bit               m_locked;
   int               m_owner;
   logic [IW+DW-1:0] m_q[$];

   typedef struct {
      bit            rst;
      logic [NR-1:0] req;
      logic [NR-1:0] last;
      bit            pop;
      logic [NR-1:0] ready;
      bit            valid;
      logic [IW-1:0] id;
      bit            locked;
   } vec_t;

   vec_t tbl[14];

   ucsbece154b_push_arbiter #(
      .DATA_WIDTH (DW),
      .NR_REQ     (NR),
      .NR_ENTRIES (NE)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req_i    (req_i),
      .last_i   (last_i),
      .data_i   (data_i),
      .ready_o  (ready_o),
      .data_o   (data_o),
      .id_o     (id_o),
      .valid_o  (valid_o),
      .pop_i    (pop_i),
      .locked_o (locked_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [NR-1:0] model_ready(input logic [NR-1:0] req);
      logic [NR-1:0] r;
      r = '0;
      if (m_q.size() >= NE) return r;
      if (m_locked) begin
         if (req[m_owner]) r[m_owner] = 1'b1;
         return r;
      end
      for (int i = 0; i < NR; i++) begin
         if (r == '0 && req[(m_rr + i) % NR]) r[(m_rr + i) % NR] = 1'b1;
      end
      return r;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      req_i = '0;
      last_i = '0;
      pop_i = 1'b0;
      #1;
      check("rst_ready", ready_o, 0);
      check("rst_valid", valid_o, 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      m_rr = 0;
      m_locked = 1'b0;
      m_owner = 0;
      m_q.delete();
   endtask

   // One model-checked cycle; rdy returns the sampled ready_o for directed assertions.
   task automatic cycle(input logic [NR-1:0] req, input logic [NR-1:0] last, input logic pop,
                        output logic [NR-1:0] rdy);
      logic [NR-1:0]    er;
      logic [IW+DW-1:0] head;
      int               g;
      req_i = req;
      last_i = last;
      pop_i = pop;
      #1;
      er = model_ready(req);
      head = (m_q.size() != 0) ? m_q[0] : '0;
      rdy = ready_o;
      check("ready", ready_o, er);
      check("valid", valid_o, m_q.size() != 0);
      check("data", data_o, head[DW-1:0]);
      check("id", id_o, head[DW +: IW]);
      check("locked", locked_o, m_locked);
      g = -1;
      for (int i = 0; i < NR; i++) if (er[i]) g = i;
      if (pop && m_q.size() != 0) void'(m_q.pop_front());
      if (g >= 0) begin
         m_q.push_back({IW'(g), data_i[g*DW +: DW]});
         m_rr = (g + 1) % NR;
         if (!m_locked && !last[g]) begin
            m_locked = 1'b1;
            m_owner = g;
         end else if (m_locked && last[g]) begin
            m_locked = 1'b0;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [NR-1:0] rdy;
      rst = 1'b1;
      req_i = '0;
      last_i = '0;
      pop_i = 1'b0;
      data_i = {32'hA3, 32'hA2, 32'hA1, 32'hA0};

      // round-robin rotation with pop, then a locked packet from requester 2
      tbl[0]  = '{1'b1, 4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
      tbl[1]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, 1'b0};
      tbl[2]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0, 1'b0};
      tbl[3]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1, 1'b0};
      tbl[4]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2, 1'b0};
      tbl[5]  = '{1'b0, 4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3, 1'b0};
      tbl[6]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0};
      tbl[7]  = '{1'b0, 4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b0, 2'd0, 1'b0};
      tbl[8]  = '{1'b0, 4'b0101, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd1, 1'b0};
      tbl[9]  = '{1'b0, 4'b0101, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1};
      tbl[10] = '{1'b0, 4'b0101, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1};
      tbl[11] = '{1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd2, 1'b0};
      tbl[12] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b0};
      tbl[13] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};

      do_reset();
      for (int v = 0; v < 14; v++) begin
         rst = tbl[v].rst;
         req_i = tbl[v].req;
         last_i = tbl[v].last;
         pop_i = tbl[v].pop;
         #1;
         check($sformatf("tbl%0d_ready", v), ready_o, tbl[v].ready);
         check($sformatf("tbl%0d_valid", v), valid_o, tbl[v].valid);
         check($sformatf("tbl%0d_id", v), id_o, tbl[v].id);
         check($sformatf("tbl%0d_locked", v), locked_o, tbl[v].locked);
         check($sformatf("tbl%0d_data", v), data_o, tbl[v].valid ? 32'hA0 + tbl[v].id : 32'h0);
         @(posedge clk);
         @(negedge clk);
      end

      // fill to full without popping; a pop while full still grants nothing
      do_reset();
      for (int i = 0; i < 4; i++) cycle(4'b0001, 4'b0001, 1'b0, rdy);
      cycle(4'b0001, 4'b0001, 1'b0, rdy);
      check("full_no_grant", rdy, 4'b0000);
      cycle(4'b0001, 4'b0001, 1'b1, rdy);
      check("full_pop_no_grant", rdy, 4'b0000);
      cycle(4'b0001, 4'b0001, 1'b0, rdy);
      check("after_pop_grant", rdy, 4'b0001);

      // wrap search from pointer 3, pointer then at 2
      do_reset();
      cycle(4'b0100, 4'b0100, 1'b1, rdy);
      cycle(4'b0010, 4'b0010, 1'b1, rdy);
      check("wrap_grant", rdy, 4'b0010);
      cycle(4'b0110, 4'b0110, 1'b1, rdy);
      check("rr_after_wrap", rdy, 4'b0100);

      // owner pauses mid-packet; others stay stalled
      do_reset();
      cycle(4'b0100, 4'b0000, 1'b1, rdy);
      for (int i = 0; i < 3; i++) begin
         cycle(4'b0001, 4'b0001, 1'b1, rdy);
         check("owner_idle_stall", rdy, 4'b0000);
      end
      cycle(4'b0101, 4'b0101, 1'b1, rdy);
      check("owner_resume", rdy, 4'b0100);
      cycle(4'b0001, 4'b0001, 1'b1, rdy);
      check("back_to_arb", rdy, 4'b0001);

      // reset while locked with three queued entries
      do_reset();
      for (int i = 0; i < 3; i++) cycle(4'b0010, 4'b0000, 1'b0, rdy);
      do_reset();
      cycle(4'b1111, 4'b1111, 1'b0, rdy);
      check("post_rst_grant", rdy, 4'b0001);

      // randomized traffic with occasional reset
      do_reset();
      for (int n = 0; n < 600; n++) begin
         logic [NR-1:0] rq, ls;
         for (int k = 0; k < NR; k++) begin
            data_i[k*DW +: DW] = $urandom;
            ls[k] = ($urandom_range(0, 3) != 0);
         end
         rq = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 149) == 0) do_reset();
         cycle(rq, ls, 1'($urandom_range(0, 1)), rdy);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
